// File: rtl/fpint_pkg.sv
// Shared types and helpers for the bit-serial FP-INT systolic array front end.
package fpint_pkg;

  localparam int ACT_WIDTH_DEF = 16;
  localparam int MAX_PREC_DEF  = 8;
  localparam int PREC_W        = 4;
  localparam int LANE_CTRL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_e;

  // Zero or out-of-range precision falls back to the widest weight format.
  function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p,
                                                   input logic [PREC_W-1:0] max_p);
    logic [PREC_W-1:0] r;
    if ((p == 4'd0) || (p > max_p)) r = max_p;
    else r = p;
    return r;
  endfunction

  function automatic int lane_width(input int act_w);
    return act_w + LANE_CTRL_W;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to skew one row lane of the feeder.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Front-end sequencer: accepts activation/weight vectors, serialises weights
// LSB-first, skews rows diagonally, drains the array and pulses done.
module systolic_feeder
  import fpint_pkg::*;
#(
  parameter int N         = 4,
  parameter int ACT_WIDTH = ACT_WIDTH_DEF,
  parameter int MAX_PREC  = MAX_PREC_DEF,
  parameter int K_WIDTH   = 8,
  parameter int PE_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             precision,
  input  logic [K_WIDTH-1:0]     k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*ACT_WIDTH-1:0] act_vec,
  input  logic [N*MAX_PREC-1:0]  w_vec,
  output logic [N*ACT_WIDTH-1:0] act_out,
  output logic [N-1:0]           w_bit_out,
  output logic [N-1:0]           row_active,
  output logic [N-1:0]           row_msb,
  output logic                   busy,
  output logic                   done
);

  localparam int BIT_W     = $clog2(MAX_PREC);
  localparam int LANE_W    = lane_width(ACT_WIDTH);
  localparam int DRAIN_CYC = N - 1 + PE_LAT;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

  feeder_state_e          state_q, state_d;
  logic [PREC_W-1:0]      prec_q, prec_d;
  logic [K_WIDTH-1:0]     k_q, k_d, acc_q, acc_d;
  logic                   cur_valid_q, cur_valid_d;
  logic [N*ACT_WIDTH-1:0] cur_act_q, cur_act_d;
  logic [N*MAX_PREC-1:0]  cur_w_q, cur_w_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   last_bit_s, hs_s;

  assign last_bit_s = cur_valid_q && (PREC_W'(bit_cnt_q) == (prec_q - 4'd1));
  assign in_ready   = (state_q == ST_STREAM) && (acc_q != k_q) && (!cur_valid_q || last_bit_s);
  assign hs_s       = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    prec_d      = prec_q;
    k_d         = k_q;
    acc_d       = acc_q;
    cur_valid_d = cur_valid_q;
    cur_act_d   = cur_act_q;
    cur_w_d     = cur_w_q;
    bit_cnt_d   = bit_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prec_d      = clamp_prec(precision, PREC_W'(MAX_PREC));
          k_d         = k_len;
          acc_d       = '0;
          cur_valid_d = 1'b0;
          bit_cnt_d   = '0;
          drain_cnt_d = '0;
          if (k_len == '0) state_d = ST_DONE;
          else state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // A handshake on the last bit reloads the holder, so vectors chain without a bubble.
        if (hs_s) begin
          cur_valid_d = 1'b1;
          cur_act_d   = act_vec;
          cur_w_d     = w_vec;
          bit_cnt_d   = '0;
          acc_d       = acc_q + K_WIDTH'(1);
        end else if (last_bit_s) begin
          cur_valid_d = 1'b0;
          bit_cnt_d   = '0;
          if (acc_q == k_q) state_d = ST_DRAIN;
          else state_d = ST_STREAM;
        end else if (cur_valid_q) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d     = ST_DONE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prec_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      cur_valid_q <= 1'b0;
      cur_act_q   <= '0;
      cur_w_q     <= '0;
      bit_cnt_q   <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prec_q      <= prec_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      cur_valid_q <= cur_valid_d;
      cur_act_q   <= cur_act_d;
      cur_w_q     <= cur_w_d;
      bit_cnt_q   <= bit_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar r = 0; r < N; r++) begin : g_row
    logic [MAX_PREC-1:0] w_row_s;
    logic [LANE_W-1:0]   lane_in_s, lane_out_s;

    // Idle lanes are forced to zero so bubbles leave no stale data on the outputs.
    assign w_row_s   = cur_w_q[r*MAX_PREC +: MAX_PREC];
    assign lane_in_s = cur_valid_q ?
                       {1'b1, last_bit_s, w_row_s[bit_cnt_q], cur_act_q[r*ACT_WIDTH +: ACT_WIDTH]} :
                       '0;

    skew_delay_line #(.DEPTH(r + 1), .WIDTH(LANE_W)) u_skew (
      .clk  (clk),
      .rst  (rst),
      .din  (lane_in_s),
      .dout (lane_out_s)
    );

    assign row_active[r]                     = lane_out_s[LANE_W-1];
    assign row_msb[r]                        = lane_out_s[LANE_W-2];
    assign w_bit_out[r]                      = lane_out_s[LANE_W-3];
    assign act_out[r*ACT_WIDTH +: ACT_WIDTH] = lane_out_s[ACT_WIDTH-1:0];
  end

endmodule
